// File: rtl/power_cone_sweep_ctrl_if.sv
// Sweep controller <-> harness bundle: start/seed request, cone stimulus and response, results.
// Latency: wires only, no storage.
// Backpressure: none; the controller ignores start while a sweep is in flight.
`timescale 1ns/1ps
interface power_cone_sweep_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [7:0]       seed_in;
  logic [3:0]       vec_out;
  logic             cone_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] out_toggles;
  logic [CNT_W-1:0] in_toggles;
  logic [CNT_W-1:0] mismatches;
  logic [3:0]       first_bad_vec;
  logic             first_bad_valid;

  // Harness side: requests sweeps and closes the loop through the cone.
  modport master (
    output start, seed_in, cone_out,
    input  vec_out, busy, done, out_toggles, in_toggles, mismatches,
           first_bad_vec, first_bad_valid
  );

  // Controller side.
  modport slave (
    input  start, seed_in, cone_out,
    output vec_out, busy, done, out_toggles, in_toggles, mismatches,
           first_bad_vec, first_bad_valid
  );
endinterface

// File: rtl/power_cone_sweep_ctrl.sv
// LFSR sweep of a 4-input cone: drives vectors, checks n_8 against golden, counts toggles.
// Latency: NUM_VEC RUN cycles after start is accepted, then a one-cycle done pulse.
// Backpressure: none; start is only honoured in IDLE, results hold until the next sweep.
`timescale 1ns/1ps
module power_cone_sweep_ctrl #(
  parameter int         NUM_VEC = 256,
  parameter int         CNT_W   = 16,
  parameter logic [7:0] SEED    = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  power_cone_sweep_ctrl_if.slave io_sw
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // An all-zero LFSR would lock up, so a zero default seed becomes 8'h01.
  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0]      LAST_IDX = 16'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_lfsr;
  // vec_out tracks lfsr[3:0] except after reset, where it must read 0 while
  // the LFSR already holds the default seed; hence its own register.
  logic [3:0]       r_vec;
  logic [15:0]      r_idx;
  logic [3:0]       r_prev_vec;
  logic             r_prev_out;
  logic [CNT_W-1:0] r_out_tog;
  logic [CNT_W-1:0] r_in_tog;
  logic [CNT_W-1:0] r_mism;
  logic [3:0]       r_fb_vec;
  logic             r_fb_vld;

  logic             w_start_acc;
  logic             w_last;
  logic [7:0]       w_lfsr_nxt;
  logic [7:0]       w_seed_sel;
  logic             w_golden;
  logic             w_bad;
  logic             w_out_chg;
  logic [3:0]       w_diff;
  logic [2:0]       w_ham;
  logic [CNT_W:0]   w_in_sum;
  logic [CNT_W-1:0] w_in_tog_nxt;
  logic [CNT_W-1:0] w_out_tog_inc;
  logic [CNT_W-1:0] w_mism_inc;

  assign w_start_acc = (r_state == S_IDLE) && io_sw.start;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_seed_sel  = (io_sw.seed_in == 8'h00) ? SEED_EFF : io_sw.seed_in;

  // Cone response is combinational from vec_out, so it is judged in the same cycle.
  assign w_golden  = r_vec[0] ^ (~r_vec[1] & r_vec[3]) ^ (r_vec[2] & r_vec[3]);
  assign w_bad     = (io_sw.cone_out != w_golden);
  assign w_out_chg = (io_sw.cone_out != r_prev_out);

  assign w_diff = r_vec ^ r_prev_vec;
  assign w_ham  = 3'(w_diff[0]) + 3'(w_diff[1]) + 3'(w_diff[2]) + 3'(w_diff[3]);

  // Saturating counter updates: a carry out of the counter width pins at all-ones.
  assign w_in_sum      = {1'b0, r_in_tog} + (CNT_W+1)'(w_ham);
  assign w_in_tog_nxt  = w_in_sum[CNT_W] ? CNT_MAX : w_in_sum[CNT_W-1:0];
  assign w_out_tog_inc = (r_out_tog == CNT_MAX) ? r_out_tog : r_out_tog + CNT_W'(1);
  assign w_mism_inc    = (r_mism == CNT_MAX) ? r_mism : r_mism + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: IDLE -> RUN on start, RUN -> DONE after the last vector, DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_sw.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep datapath: seed load on start, one vector per RUN cycle with checking and toggle counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr     <= SEED_EFF;
      r_vec      <= '0;
      r_idx      <= '0;
      r_prev_vec <= '0;
      r_prev_out <= 1'b0;
      r_out_tog  <= '0;
      r_in_tog   <= '0;
      r_mism     <= '0;
      r_fb_vec   <= '0;
      r_fb_vld   <= 1'b0;
    end else if (w_start_acc) begin
      r_lfsr     <= w_seed_sel;
      r_vec      <= w_seed_sel[3:0];
      r_idx      <= '0;
      r_prev_vec <= '0;
      r_prev_out <= 1'b0;
      r_out_tog  <= '0;
      r_in_tog   <= '0;
      r_mism     <= '0;
      r_fb_vec   <= '0;
      r_fb_vld   <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_bad) begin
        r_mism <= w_mism_inc;
        if (!r_fb_vld) begin
          r_fb_vec <= r_vec;
          r_fb_vld <= 1'b1;
        end
      end
      // The first vector has no predecessor, so it contributes no toggles.
      if (r_idx != 16'd0) begin
        if (w_out_chg) r_out_tog <= w_out_tog_inc;
        r_in_tog <= w_in_tog_nxt;
      end
      r_prev_vec <= r_vec;
      r_prev_out <= io_sw.cone_out;
      // The LFSR stops on the last vector so vec_out keeps showing it afterwards.
      if (!w_last) begin
        r_lfsr <= w_lfsr_nxt;
        r_vec  <= w_lfsr_nxt[3:0];
        r_idx  <= r_idx + 16'd1;
      end
    end
  end

  assign io_sw.vec_out         = r_vec;
  assign io_sw.busy            = (r_state != S_IDLE);
  assign io_sw.done            = (r_state == S_DONE);
  assign io_sw.out_toggles     = r_out_tog;
  assign io_sw.in_toggles      = r_in_tog;
  assign io_sw.mismatches      = r_mism;
  assign io_sw.first_bad_vec   = r_fb_vec;
  assign io_sw.first_bad_valid = r_fb_vld;

endmodule

// File: tb/tb_power_cone_sweep_ctrl.sv
// Bench for power_cone_sweep_ctrl: three instances (NUM_VEC 4, 256, 1) with their own cone models.
// Latency: checks sweep length, done timing and final results against a vector-list model.
// Backpressure: none; exercises start being ignored while busy.
`timescale 1ns/1ps
module tb_power_cone_sweep_ctrl;

  localparam int          NI        = 3;
  // Truth table of n_8 indexed by {n_4,n_3,n_2,n_1}.
  localparam logic [15:0] GOLDEN_TT = 16'h69AA;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Cone behaviour per instance: 0 = correct, 1 = stuck-at-0, 2 = missing n_3&n_4 term.
  int          cone_mode [NI];
  logic        start_v   [NI];
  logic [7:0]  seed_v    [NI];
  logic        busy_v    [NI];
  logic        done_v    [NI];
  logic        fbval_v   [NI];
  logic [3:0]  vec_v     [NI];
  logic [3:0]  fbv_v     [NI];
  logic [15:0] ot_v      [NI];
  logic [15:0] it_v      [NI];
  logic [15:0] mm_v      [NI];

  function automatic logic cone_fn(input logic [3:0] v, input int mode);
    case (mode)
      0:       return v[0] ^ (~v[1] & v[3]) ^ (v[2] & v[3]);
      1:       return 1'b0;
      default: return v[0] ^ (~v[1] & v[3]);
    endcase
  endfunction

  function automatic int nvec_of(input int w);
    case (w)
      0:       return 4;
      1:       return 256;
      default: return 1;
    endcase
  endfunction

  power_cone_sweep_ctrl_if #(.CNT_W(16)) if0 ();
  power_cone_sweep_ctrl_if #(.CNT_W(16)) if1 ();
  power_cone_sweep_ctrl_if #(.CNT_W(16)) if2 ();

  power_cone_sweep_ctrl #(.NUM_VEC(4),   .CNT_W(16), .SEED(8'h01)) u_dut4   (.clk(clk), .rst(rst), .io_sw(if0));
  power_cone_sweep_ctrl #(.NUM_VEC(256), .CNT_W(16), .SEED(8'h01)) u_dut256 (.clk(clk), .rst(rst), .io_sw(if1));
  power_cone_sweep_ctrl #(.NUM_VEC(1),   .CNT_W(16), .SEED(8'h01)) u_dut1   (.clk(clk), .rst(rst), .io_sw(if2));

  assign if0.start = start_v[0];  assign if0.seed_in = seed_v[0];
  assign if1.start = start_v[1];  assign if1.seed_in = seed_v[1];
  assign if2.start = start_v[2];  assign if2.seed_in = seed_v[2];
  assign if0.cone_out = cone_fn(if0.vec_out, cone_mode[0]);
  assign if1.cone_out = cone_fn(if1.vec_out, cone_mode[1]);
  assign if2.cone_out = cone_fn(if2.vec_out, cone_mode[2]);

  assign busy_v[0] = if0.busy;  assign done_v[0] = if0.done;  assign vec_v[0] = if0.vec_out;
  assign busy_v[1] = if1.busy;  assign done_v[1] = if1.done;  assign vec_v[1] = if1.vec_out;
  assign busy_v[2] = if2.busy;  assign done_v[2] = if2.done;  assign vec_v[2] = if2.vec_out;
  assign ot_v[0] = if0.out_toggles;  assign it_v[0] = if0.in_toggles;  assign mm_v[0] = if0.mismatches;
  assign ot_v[1] = if1.out_toggles;  assign it_v[1] = if1.in_toggles;  assign mm_v[1] = if1.mismatches;
  assign ot_v[2] = if2.out_toggles;  assign it_v[2] = if2.in_toggles;  assign mm_v[2] = if2.mismatches;
  assign fbv_v[0] = if0.first_bad_vec;  assign fbval_v[0] = if0.first_bad_valid;
  assign fbv_v[1] = if1.first_bad_vec;  assign fbval_v[1] = if1.first_bad_valid;
  assign fbv_v[2] = if2.first_bad_vec;  assign fbval_v[2] = if2.first_bad_valid;

  // Next state of the 8-bit Fibonacci LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference: walk the vector list, judge each against the truth table, sum toggles, then clamp.
  function automatic void model(input logic [7:0] seed, input int nvec, input int mode,
                                output int ot, output int it, output int mm,
                                output logic [3:0] fbv, output logic fbval);
    logic [7:0]  l;
    logic [3:0]  v, pv;
    logic        c, pc;
    logic [15:0] tt;
    tt = GOLDEN_TT;
    l  = (seed == 8'h00) ? 8'h01 : seed;
    ot = 0; it = 0; mm = 0; fbv = 4'h0; fbval = 1'b0; pv = 4'h0; pc = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      v = l[3:0];
      c = cone_fn(v, mode);
      if (c != tt[v]) begin
        mm++;
        if (!fbval) begin fbv = v; fbval = 1'b1; end
      end
      if (i > 0) begin
        ot += int'(c != pc);
        it += $countones(v ^ pv);
      end
      pv = v; pc = c;
      l  = lfsr_step(l);
    end
    if (ot > 65535) ot = 65535;
    if (it > 65535) it = 65535;
    if (mm > 65535) mm = 65535;
  endfunction

  // Pulses start on instance w, then watches a fixed window of NUM_VEC+8 cycles.
  // k counts clock edges after start is raised; s1/s2 (if nonzero) re-raise start after edge k.
  task automatic run_sweep(input int w, input logic [7:0] seed, input int mode,
                           input int s1, input int s2,
                           output int t_done, output int n_busy, output int n_done,
                           output int bad_vecs);
    logic [7:0] l;
    int         run_i;
    cone_mode[w] = mode;
    l = (seed == 8'h00) ? 8'h01 : seed;
    t_done = -1; n_busy = 0; n_done = 0; bad_vecs = 0; run_i = 0;
    @(posedge clk); #1;
    seed_v[w]  = seed;
    start_v[w] = 1'b1;
    for (int k = 1; k <= nvec_of(w) + 8; k++) begin
      @(posedge clk); #1;
      if (busy_v[w]) n_busy++;
      if (done_v[w]) begin
        n_done++;
        if (t_done < 0) t_done = k;
      end
      if (busy_v[w] && !done_v[w] && run_i < nvec_of(w)) begin
        if (vec_v[w] !== l[3:0]) bad_vecs++;
        l = lfsr_step(l);
        run_i++;
      end
      start_v[w] = (k == s1) || (k == s2);
    end
    start_v[w] = 1'b0;
  endtask

  task automatic test_reset();
    int busy_seen;
    rst = 1'b0;
    #11;
    rst = 1'b1;
    #1;
    for (int w = 0; w < NI; w++) begin
      checks++;
      if ({busy_v[w], done_v[w], vec_v[w], ot_v[w], it_v[w], mm_v[w], fbv_v[w], fbval_v[w]} !== '0)
        begin failures++;
        $display("FAIL reset_outputs inst%0d: got busy=%b done=%b vec=%h ot=%0d it=%0d mm=%0d fbv=%h fbval=%b required all 0",
                 w, busy_v[w], done_v[w], vec_v[w], ot_v[w], it_v[w], mm_v[w], fbv_v[w], fbval_v[w]); end
    end
    #20;
    rst = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      for (int w = 0; w < NI; w++) if (busy_v[w]) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin failures++;
      $display("FAIL idle_busy: got %0d busy samples required 0", busy_seen); end
    for (int w = 0; w < NI; w++) begin
      checks++;
      if ({vec_v[w], ot_v[w], it_v[w], mm_v[w], fbval_v[w], done_v[w]} !== '0) begin failures++;
        $display("FAIL idle_hold inst%0d: got vec=%h mm=%0d done=%b required zeros", w, vec_v[w], mm_v[w], done_v[w]); end
    end
  endtask

  task automatic test_correct_cone();
    int t_done, n_busy, n_done, bad;
    run_sweep(0, 8'h01, 0, 0, 0, t_done, n_busy, n_done, bad);
    checks++; if (bad !== 0)      begin failures++; $display("FAIL correct_vec_seq: got %0d bad vectors required 0", bad); end
    checks++; if (t_done !== 5)   begin failures++; $display("FAIL correct_done_time: got %0d required 5", t_done); end
    checks++; if (n_done !== 1)   begin failures++; $display("FAIL correct_done_count: got %0d required 1", n_done); end
    checks++; if (n_busy !== 5)   begin failures++; $display("FAIL correct_busy_len: got %0d required 5", n_busy); end
    checks++; if (ot_v[0] !== 16'd2) begin failures++; $display("FAIL correct_out_toggles: got %0d required 2", ot_v[0]); end
    checks++; if (it_v[0] !== 16'd6) begin failures++; $display("FAIL correct_in_toggles: got %0d required 6", it_v[0]); end
    checks++; if (mm_v[0] !== 16'd0) begin failures++; $display("FAIL correct_mismatches: got %0d required 0", mm_v[0]); end
    checks++; if ({fbval_v[0], fbv_v[0]} !== 5'h00) begin failures++;
      $display("FAIL correct_first_bad: got valid=%b vec=%h required 0/0", fbval_v[0], fbv_v[0]); end
    checks++; if (vec_v[0] !== 4'h8) begin failures++; $display("FAIL correct_vec_hold: got %h required 8", vec_v[0]); end
  endtask

  task automatic test_faulty_cone();
    int t_done, n_busy, n_done, bad;
    run_sweep(0, 8'h01, 1, 0, 0, t_done, n_busy, n_done, bad);
    checks++; if (t_done !== 5)      begin failures++; $display("FAIL stuck_done_time: got %0d required 5", t_done); end
    checks++; if (mm_v[0] !== 16'd2) begin failures++; $display("FAIL stuck_mismatches: got %0d required 2", mm_v[0]); end
    checks++; if (fbv_v[0] !== 4'h1) begin failures++; $display("FAIL stuck_first_bad_vec: got %h required 1", fbv_v[0]); end
    checks++; if (fbval_v[0] !== 1'b1) begin failures++; $display("FAIL stuck_first_bad_valid: got %b required 1", fbval_v[0]); end
    checks++; if (ot_v[0] !== 16'd0) begin failures++; $display("FAIL stuck_out_toggles: got %0d required 0", ot_v[0]); end
    checks++; if (it_v[0] !== 16'd6) begin failures++; $display("FAIL stuck_in_toggles: got %0d required 6", it_v[0]); end
  endtask

  task automatic test_default_run();
    int t_done, n_busy, n_done, bad, e_ot, e_it, e_mm;
    logic [3:0] e_fbv;
    logic       e_fbval;
    model(8'h00, 256, 0, e_ot, e_it, e_mm, e_fbv, e_fbval);
    run_sweep(1, 8'h00, 0, 0, 0, t_done, n_busy, n_done, bad);
    checks++; if (n_busy !== 257) begin failures++; $display("FAIL default_busy_len: got %0d required 257", n_busy); end
    checks++; if (n_done !== 1)   begin failures++; $display("FAIL default_done_count: got %0d required 1", n_done); end
    checks++; if (bad !== 0)      begin failures++; $display("FAIL default_vec_seq: got %0d bad vectors required 0", bad); end
    checks++; if (mm_v[1] !== 16'd0) begin failures++; $display("FAIL default_mismatches: got %0d required 0", mm_v[1]); end
    checks++; if (ot_v[1] !== 16'(e_ot)) begin failures++; $display("FAIL default_out_toggles: got %0d required %0d", ot_v[1], e_ot); end
    checks++; if (it_v[1] !== 16'(e_it)) begin failures++; $display("FAIL default_in_toggles: got %0d required %0d", it_v[1], e_it); end
  endtask

  task automatic test_single_vector();
    int t_done, n_busy, n_done, bad;
    run_sweep(2, 8'h01, 1, 0, 0, t_done, n_busy, n_done, bad);
    checks++; if (t_done !== 2) begin failures++; $display("FAIL nv1_done_time: got %0d required 2", t_done); end
    checks++; if (n_busy !== 2) begin failures++; $display("FAIL nv1_busy_len: got %0d required 2", n_busy); end
    checks++; if ({ot_v[2], it_v[2]} !== 32'd0) begin failures++;
      $display("FAIL nv1_toggles: got ot=%0d it=%0d required 0/0", ot_v[2], it_v[2]); end
    checks++; if ({mm_v[2], fbval_v[2], fbv_v[2]} !== {16'd1, 1'b1, 4'h1}) begin failures++;
      $display("FAIL nv1_mismatch: got mm=%0d valid=%b vec=%h required 1/1/1", mm_v[2], fbval_v[2], fbv_v[2]); end
  endtask

  task automatic test_random_sweeps();
    int t_done, n_busy, n_done, bad, w, mode, e_ot, e_it, e_mm;
    logic [7:0] seed;
    logic [3:0] e_fbv;
    logic       e_fbval;
    for (int n = 0; n < 10; n++) begin
      w    = $urandom_range(0, 2);
      mode = $urandom_range(0, 2);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      model(seed, nvec_of(w), mode, e_ot, e_it, e_mm, e_fbv, e_fbval);
      run_sweep(w, seed, mode, 0, 0, t_done, n_busy, n_done, bad);
      checks++;
      if (t_done !== nvec_of(w) + 1 || n_done !== 1 || bad !== 0) begin failures++;
        $display("FAIL rand_timing #%0d inst%0d seed=%h: got done_at=%0d dones=%0d badvec=%0d required %0d/1/0",
                 n, w, seed, t_done, n_done, bad, nvec_of(w) + 1); end
      checks++;
      if (ot_v[w] !== 16'(e_ot) || it_v[w] !== 16'(e_it) || mm_v[w] !== 16'(e_mm) ||
          fbv_v[w] !== e_fbv || fbval_v[w] !== e_fbval) begin failures++;
        $display("FAIL rand_results #%0d inst%0d seed=%h mode=%0d: got ot=%0d it=%0d mm=%0d fbv=%h fbval=%b required %0d/%0d/%0d/%h/%b",
                 n, w, seed, mode, ot_v[w], it_v[w], mm_v[w], fbv_v[w], fbval_v[w],
                 e_ot, e_it, e_mm, e_fbv, e_fbval); end
    end
  endtask

  task automatic test_start_ignored();
    int t_done, n_busy, n_done, bad;
    // Edge 3 shows RUN idx 2; edge 5 shows DONE.
    run_sweep(0, 8'h01, 0, 3, 5, t_done, n_busy, n_done, bad);
    checks++; if (t_done !== 5 || n_done !== 1) begin failures++;
      $display("FAIL ignored_done: got at=%0d count=%0d required 5/1", t_done, n_done); end
    checks++; if (n_busy !== 5) begin failures++; $display("FAIL ignored_busy_len: got %0d required 5", n_busy); end
    checks++; if ({ot_v[0], it_v[0], mm_v[0]} !== {16'd2, 16'd6, 16'd0}) begin failures++;
      $display("FAIL ignored_results: got ot=%0d it=%0d mm=%0d required 2/6/0", ot_v[0], it_v[0], mm_v[0]); end
  endtask

  task automatic test_reset_mid_run();
    int t_done, n_busy, n_done, bad, busy_seen, done_seen;
    cone_mode[0] = 1;
    @(posedge clk); #1;
    seed_v[0] = 8'h01; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_v[0], done_v[0], vec_v[0], ot_v[0], it_v[0], mm_v[0], fbv_v[0], fbval_v[0]} !== '0) begin failures++;
      $display("FAIL midrun_reset: got busy=%b vec=%h mm=%0d fbval=%b required all 0", busy_v[0], vec_v[0], mm_v[0], fbval_v[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    busy_seen = 0; done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy_v[0]) busy_seen++;
      if (done_v[0]) done_seen++;
    end
    checks++; if (busy_seen !== 0 || done_seen !== 0) begin failures++;
      $display("FAIL midrun_no_done: got busy=%0d done=%0d samples required 0/0", busy_seen, done_seen); end
    run_sweep(0, 8'h01, 0, 0, 0, t_done, n_busy, n_done, bad);
    checks++;
    if (t_done !== 5 || {ot_v[0], it_v[0], mm_v[0]} !== {16'd2, 16'd6, 16'd0} || fbval_v[0] !== 1'b0) begin failures++;
      $display("FAIL midrun_fresh_sweep: got at=%0d ot=%0d it=%0d mm=%0d fbval=%b required 5/2/6/0/0",
               t_done, ot_v[0], it_v[0], mm_v[0], fbval_v[0]); end
  endtask

  initial begin
    for (int w = 0; w < NI; w++) begin
      start_v[w] = 1'b0; seed_v[w] = 8'h00; cone_mode[w] = 0;
    end
    test_reset();
    test_correct_cone();
    test_faulty_cone();
    test_default_run();
    test_single_vector();
    test_random_sweeps();
    test_start_ignored();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
